// File: rtl/tdm_demux2.sv
// Receive side of a 2:1 sample-interleaved link. Splits the stream into per-channel held
// registers, emits completed channel pairs, and tracks frame alignment with a lock FSM.
module tdm_demux2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             DV,
  input  logic             SYNC,
  input  logic             CLR,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic             V1,
  output logic             V2,
  output logic [WIDTH-1:0] P1,
  output logic [WIDTH-1:0] P2,
  output logic             PV,
  output logic             LOCK,
  output logic             ERR
);

  typedef enum logic [1:0] {StHunt, StExp1, StExp2} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] h0_q;  // channel-1 half waiting for its channel-2 partner

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StHunt;
      h0_q    <= '0;
      Y1      <= '0;
      Y2      <= '0;
      P1      <= '0;
      P2      <= '0;
      V1      <= 1'b0;
      V2      <= 1'b0;
      PV      <= 1'b0;
      LOCK    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      V1 <= 1'b0;
      V2 <= 1'b0;
      PV <= 1'b0;
      // Clear first so an error set below at the same edge takes priority.
      if (CLR) ERR <= 1'b0;
      if (DV) begin
        unique case (state_q)
          StHunt: begin
            if (SYNC) begin
              Y1      <= D;
              h0_q    <= D;
              V1      <= 1'b1;
              state_q <= StExp2;
              LOCK    <= 1'b1;
            end
          end
          StExp2: begin
            if (SYNC) begin
              // Channel-2 sample missing: restart the pair on this channel-1 sample.
              Y1   <= D;
              h0_q <= D;
              V1   <= 1'b1;
              ERR  <= 1'b1;
            end else begin
              Y2      <= D;
              V2      <= 1'b1;
              P1      <= h0_q;
              P2      <= D;
              PV      <= 1'b1;
              state_q <= StExp1;
            end
          end
          StExp1: begin
            if (SYNC) begin
              Y1      <= D;
              h0_q    <= D;
              V1      <= 1'b1;
              state_q <= StExp2;
            end else begin
              ERR     <= 1'b1;
              state_q <= StHunt;
              LOCK    <= 1'b0;
            end
          end
          default: begin
            state_q <= StHunt;
            LOCK    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux2.sv
// Directed bench for tdm_demux2: a rule-level model checked on every cycle, plus literal
// expectations at key points of each scenario.
module tb_tdm_demux2;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst, dv, sync, clr;
  logic [W-1:0] d;
  logic [W-1:0] y1, y2, p1, p2;
  logic         v1, v2, pv, lock, err;

  tdm_demux2 #(.WIDTH(W)) dut (
    .CLK (clk),
    .RST (rst),
    .D   (d),
    .DV  (dv),
    .SYNC(sync),
    .CLR (clr),
    .Y1  (y1),
    .Y2  (y2),
    .V1  (v1),
    .V2  (v2),
    .P1  (p1),
    .P2  (p2),
    .PV  (pv),
    .LOCK(lock),
    .ERR (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  // Model: "locked" means aligned to the frame; "pending" means a channel-1 sample is waiting.
  bit           m_locked, m_pending;
  logic [W-1:0] m_y1, m_y2, m_p1, m_p2, m_half;
  bit           m_v1, m_v2, m_pv, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_locked = 0; m_pending = 0; m_err = 0;
      m_y1 = '0; m_y2 = '0; m_p1 = '0; m_p2 = '0; m_half = '0;
      m_v1 = 0; m_v2 = 0; m_pv = 0;
      return;
    end
    m_v1 = 0; m_v2 = 0; m_pv = 0;
    if (clr) m_err = 0;
    if (!dv) return;
    if (sync) begin
      if (m_locked && m_pending) m_err = 1;
      m_y1 = d; m_half = d; m_v1 = 1;
      m_locked = 1; m_pending = 1;
    end else if (m_locked && m_pending) begin
      m_y2 = d; m_v2 = 1; m_p1 = m_half; m_p2 = d; m_pv = 1;
      m_pending = 0;
    end else if (m_locked) begin
      m_err = 1; m_locked = 0;
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("y1", y1, m_y1);
      chk("y2", y2, m_y2);
      chk("p1", p1, m_p1);
      chk("p2", p2, m_p2);
      chk("v1", v1, m_v1);
      chk("v2", v2, m_v2);
      chk("pv", pv, m_pv);
      chk("lock", lock, m_locked);
      chk("err", err, m_err);
    end
  end

  task automatic step(input bit r, input bit v, input bit s, input logic [W-1:0] data,
                      input bit c = 1'b0);
    rst = r; dv = v; sync = s; d = data; clr = c;
    @(posedge clk);
    model_edge();
    checking = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic smp(input bit s, input logic [W-1:0] data);
    step(1'b0, 1'b1, s, data);
  endtask

  task automatic idle(input bit c = 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, c);
  endtask

  initial begin
    rst = 1'b0; dv = 1'b0; sync = 1'b0; clr = 1'b0; d = '0;
    @(negedge clk);

    // Reset then clean stream
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("rst_y1", y1, 8'h00);
    chk("rst_lock", lock, 1'b0);
    smp(1'b1, 8'h11);
    chk("c_y1", y1, 8'h11);
    chk("c_v1", v1, 1'b1);
    chk("c_lock", lock, 1'b1);
    smp(1'b0, 8'h22);
    chk("c_pair", {p1, p2, pv, v2}, {8'h11, 8'h22, 1'b1, 1'b1});
    smp(1'b1, 8'h33);
    chk("c_y1b", y1, 8'h33);
    smp(1'b0, 8'h44);
    chk("c_pair2", {p1, p2, pv, err}, {8'h33, 8'h44, 1'b1, 1'b0});

    // Hunt drop
    step(1'b1, 1'b0, 1'b0, 8'h00);
    smp(1'b0, 8'hAA);
    smp(1'b0, 8'hBB);
    chk("h_drop", {y1, y2, v1, v2, lock}, {8'h00, 8'h00, 3'b000});
    smp(1'b1, 8'hCC);
    chk("h_y1", {y1, lock}, {8'hCC, 1'b1});
    smp(1'b0, 8'hDD);
    chk("h_pair", {p1, p2, pv}, {8'hCC, 8'hDD, 1'b1});

    // Gapped DV
    smp(1'b1, 8'h01);
    repeat (3) idle();
    chk("g_hold", {y1, v1, v2, pv}, {8'h01, 3'b000});
    smp(1'b0, 8'h02);
    chk("g_pair", {p1, p2, pv}, {8'h01, 8'h02, 1'b1});

    // Missing channel 2
    smp(1'b1, 8'h10);
    smp(1'b1, 8'h20);
    chk("m_err", {err, lock, pv, y1}, {3'b110, 8'h20});
    smp(1'b0, 8'h30);
    chk("m_pair", {p1, p2, pv}, {8'h20, 8'h30, 1'b1});

    // Sync loss and CLR
    idle(1'b1);
    chk("s_clr0", err, 1'b0);
    smp(1'b1, 8'h01);
    smp(1'b0, 8'h02);
    smp(1'b0, 8'h03);
    chk("s_loss", {err, lock, y1, y2, p1, p2}, {2'b10, 8'h01, 8'h02, 8'h01, 8'h02});
    idle(1'b1);
    chk("s_clr", err, 1'b0);
    smp(1'b1, 8'h04);
    step(1'b0, 1'b1, 1'b1, 8'h05, 1'b1);
    chk("s_setwins", err, 1'b1);

    // Reset mid-frame
    smp(1'b1, 8'h5A);
    step(1'b1, 1'b1, 1'b0, 8'h6B);
    chk("r_clear", {y1, y2, p1, p2, lock, pv, err}, {32'h0, 3'b000});
    smp(1'b0, 8'h77);
    chk("r_drop", {y2, lock, v2}, {8'h00, 2'b00});

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux2.md
Name: tdm_demux2

Overview:
Two-channel time-division demultiplexer: the receive end of a 2:1 sample-interleaved link whose transmitter alternates channel 1 and channel 2 onto one bus.
- Accepts a stream of samples, where SYNC marks every channel-1 sample.
- Routes each sample to a per-channel held register.
- Presents completed channel pairs together on a snapshot output.
- Tracks frame alignment with a small lock FSM and a sticky error flag.

Parameters:
WIDTH, 8, bit width of each sample and of all data outputs

Ports:
CLK  input  1  clock; all logic on rising edge
RST  input  1  reset, synchronous, active-high
D  input  WIDTH  interleaved sample in
DV  input  1  D valid this cycle; a sample is accepted on any edge with DV=1
SYNC  input  1  qualifies D as a channel-1 sample; ignored when DV=0
CLR  input  1  clears ERR
Y1  output  WIDTH  last accepted channel-1 sample (held)
Y2  output  WIDTH  last accepted channel-2 sample (held)
V1  output  1  one-cycle strobe: Y1 updated
V2  output  1  one-cycle strobe: Y2 updated
P1  output  WIDTH  channel-1 half of last completed pair
P2  output  WIDTH  channel-2 half of last completed pair
PV  output  1  one-cycle strobe: P1/P2 updated together
LOCK  output  1  1 when FSM is not in HUNT
ERR  output  1  sticky alignment error

Behaviour:
- Reset (RST=1 at an edge) overrides all other inputs:
  - FSM goes to HUNT.
  - Y1, Y2, P1, P2 and the internal pending channel-1 register (H0) are cleared to 0.
  - V1, V2, PV, LOCK and ERR go to 0.
  - A reset mid-frame discards any partial pair.
- All outputs are registered, with latency 1. A sample accepted at edge n is visible on the outputs, and its strobe is high, from edge n until edge n+1.
- V1, V2 and PV are high only in the cycle following an accepting edge. They are 0 in every other cycle, including every cycle after a DV=0 edge.
- DV=0 at an edge: state, Y*, P*, H0 and ERR are unchanged (except for CLR), and all strobes are 0.
- FSM states: HUNT, EXP1 (expecting channel 1), EXP2 (expecting channel 2).
- HUNT:
  - DV & SYNC: Y1<=D, H0<=D, V1=1, go to EXP2.
  - DV & !SYNC: sample dropped with no output change; stay in HUNT.
- EXP2:
  - DV & !SYNC: Y2<=D, V2=1, P1<=H0, P2<=D, PV=1, go to EXP1.
  - DV & SYNC (channel-2 sample missing): Y1<=D, H0<=D, V1=1, ERR<=1, stay in EXP2. No PV; the old H0 is discarded.
- EXP1:
  - DV & SYNC: Y1<=D, H0<=D, V1=1, go to EXP2.
  - DV & !SYNC (sync lost): sample dropped, ERR<=1, go to HUNT. No strobes.
- LOCK = (state != HUNT), registered alongside the state.
- ERR is sticky:
  - Set on either error transition above.
  - Cleared by CLR=1 at an edge.
  - If an error and CLR=1 occur at the same edge, the set wins and ERR=1.
  - ERR is not cleared by re-lock.
- V1 and V2 are never both 1 in the same cycle. PV coincides with V2 only.
- Data is passed unmodified: no arithmetic, no width change.

Test Plan:
- Reset then clean stream: RST 1 cycle, then DV=1 for 4 cycles with D=0x11(SYNC), 0x22, 0x33(SYNC), 0x44.
  - Y1=0x11 with V1, then Y2=0x22 with V2/PV, P1=0x11, P2=0x22.
  - Then Y1=0x33, then P1=0x33, P2=0x44 with PV.
  - LOCK=1 from the first accept onward; ERR=0.
- Hunt drop: after reset, D=0xAA(!SYNC), 0xBB(!SYNC), 0xCC(SYNC), 0xDD.
  - The first two are dropped: Y1, Y2 stay 0 with no strobes and LOCK=0.
  - Then Y1=0xCC, LOCK=1, then PV with P1=0xCC, P2=0xDD.
- Gapped DV: 0x01(SYNC), DV=0 for 3 cycles, then 0x02.
  - No strobes during the gap; Y1 holds 0x01.
  - PV arrives one cycle after 0x02 is accepted, with P1=0x01, P2=0x02.
- Missing channel 2: 0x10(SYNC), 0x20(SYNC), 0x30.
  - ERR=1 after the second sample; LOCK stays 1; no PV for 0x10.
  - Then P1=0x20, P2=0x30 with PV.
- Sync loss and CLR: locked pair 0x01/0x02, then 0x03(!SYNC).
  - Dropped; ERR=1, LOCK=0, and Y1/Y2/P1/P2 unchanged.
  - CLR pulse then sets ERR=0.
  - CLR asserted at the same edge as a new error leaves ERR=1.
- Reset mid-frame: 0x5A(SYNC) accepted, RST at the next edge with DV=1, SYNC=0, D=0x6B.
  - All outputs 0, LOCK=0, no PV.
  - The next non-SYNC sample is dropped.
